slave_top: RTL and testbench
============================

// Module: slave_top
// PURPOSE
//  - SPI slave (mode 0, MSB first) giving an external master access to a
//    256 x 16-bit register file, with a 16-bit LED display output.
//  - Top level of the FPGA slave board: a 100 MHz system clock oversamples
//    the asynchronous SPI pins, and the LEDs show the last word written.
// PARAMETERS
//  - SYNC_STAGES  2    flip-flop stages on sclk/mosi/cs_n before edge detection
//  - ADDR_W       8    register-file address width (depth = 2**ADDR_W = 256)
//  - DATA_W       16   register and data-phase width
// PORTS
//  - clk           in   1   100 MHz system clock; all logic on posedge
//  - rst_btn       in   1   reset, asynchronous, active-high
//  - spi_sclk_in   in   1   SPI clock from master, async; idles low
//  - spi_mosi_in   in   1   master-out data, async
//  - spi_cs_n_in   in   1   chip select, active-low, async
//  - spi_miso_out  out  1   slave-out data
//  - led           out  16  last data word written over SPI
// BEHAVIOUR
//  - Reset (async, rst_btn=1): led=0, spi_miso_out=0, FSM=IDLE, bit counter=0,
//    all 256 registers cleared to 0x0000.
//  - Input sync: sclk, mosi, cs_n pass through SYNC_STAGES flops.
//    Rise/fall detection compares the synced sclk with its previous value.
//    SCLK high and low times must each be >= 2 clk (25 MHz max).
//  - Frame: cs_n low, then 32 SCLK rising edges: 16-bit command, then 16-bit data.
//  - Command word, MSB first: [15:11] ignored, [10:3] address, [2] ignored,
//    [1] R/W (1=read, 0=write), [0] ignored.
//  - MOSI is sampled on each detected SCLK rise and shifted in MSB first.
//  - FSM: IDLE -> CMD on cs_n fall. CMD counts 16 rises, then latches addr and
//    R/W, then goes to WR_DATA (R/W=0) or RD_DATA (R/W=1).
//  - WR_DATA: shift in 16 bits. On the 16th rise: mem[addr] <= data and
//    led <= data in the same clk, then -> DONE.
//  - RD_DATA: in the clk the command is decoded, load the shift register with
//    mem[addr] and drive bit 15 on MISO. This is valid well before the first
//    data rise. After each detected data-phase rise, advance MISO to the next
//    bit within 3 clk, i.e. during SCLK low before the next rise.
//    After 16 rises -> DONE.
//  - DONE: ignore further SCLK edges until cs_n rises.
//  - cs_n high in any state -> IDLE in next clk, counters cleared, MISO=0.
//  - Early cs_n release (partial frame): abort; no register write, led unchanged.
//  - spi_miso_out = 0 whenever not in RD_DATA. It is never tri-stated.
//  - Writes persist across frames. Registers are read-only to the SPI master
//    except via write frames. Any address 0x00-0xFF is valid, with no wrap
//    or aliasing.
//  - Reading an address never written since reset returns 0x0000.
//  - rst_btn during a frame aborts it immediately. The next transfer needs a
//    fresh cs_n fall.
// TESTING
//  - Reset 5 clk, cs_n=1 -> led=0x0000, spi_miso_out=0.
//  - Write addr 0x05 data 0xAAAA (SCLK 25 MHz), cs_n high 5 clk -> led=0xAAAA.
//  - Read addr 0x05, master samples MISO at each SCLK rise -> 0xAAAA.
//  - Write 0x42=0x1234 then read 0x42 -> 0x1234, led=0x1234.
//    Then read 0x05 -> 0xAAAA (persistence).
//  - Write 0x10=0xBEEF but release cs_n after 20 SCLKs -> read 0x10 returns
//    0x0000, led unchanged.
//  - Read never-written addr 0xFF -> 0x0000. Assert rst_btn mid-read ->
//    miso=0, next frame works normally.

Source files
------------

// File: rtl/slave_top.sv
// SPI mode-0 slave bridging an external master to a 256 x 16-bit register file.
// The SPI pins are oversampled by the system clock; the LEDs mirror the last word written.
module slave_top #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_btn,
  input  logic              spi_sclk_in,
  input  logic              spi_mosi_in,
  input  logic              spi_cs_n_in,
  output logic              spi_miso_out,
  output logic [DATA_W-1:0] led
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_DATA,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-2:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic              w_sclk_s;
  logic              w_mosi_s;
  logic              w_cs_s;
  logic              w_rise;
  logic              w_cs_fall;
  logic              w_last;
  logic [DATA_W-1:0] w_word;
  logic              w_cmd_shift;
  logic              w_cmd_done;
  logic              w_wr_shift;
  logic              w_wr_done;
  logic              w_rd_shift;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk_s & ~r_sclk_prev;
  assign w_cs_fall = r_cs_prev & ~w_cs_s;
  assign w_last    = w_rise && (r_cnt == LAST_BIT);
  assign w_word    = {r_rx, w_mosi_s};

  // cs_n chain resets low so that a reset taken mid-frame (cs_n still low)
  // cannot manufacture a falling edge; a genuine high-then-low is required.
  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_in};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_cs_s) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_cs_fall) w_next = S_CMD;
        S_CMD:     if (w_last) w_next = w_word[1] ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA: if (w_last) w_next = S_DONE;
        S_RD_DATA: if (w_last) w_next = S_DONE;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cmd_shift  = 1'b0;
    w_cmd_done   = 1'b0;
    w_wr_shift   = 1'b0;
    w_wr_done    = 1'b0;
    w_rd_shift   = 1'b0;
    spi_miso_out = 1'b0;
    if (!w_cs_s) begin
      case (r_state)
        S_CMD: begin
          w_cmd_shift = w_rise;
          w_cmd_done  = w_last;
        end
        S_WR_DATA: begin
          w_wr_shift = w_rise;
          w_wr_done  = w_last;
        end
        S_RD_DATA: begin
          w_rd_shift = w_rise;
        end
        default: ;
      endcase
    end
    if (r_state == S_RD_DATA) begin
      spi_miso_out = r_tx[DATA_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst_btn) begin
    if (rst_btn) begin
      r_cnt  <= '0;
      r_rx   <= '0;
      r_tx   <= '0;
      r_addr <= '0;
      led    <= '0;
      for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_cs_s || r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (w_cmd_shift || w_wr_shift || w_rd_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_cmd_shift || w_wr_shift) begin
        r_rx <= w_word[DATA_W-2:0];
      end

      // Decode uses the word including the bit arriving on this rise, so the
      // first read bit is on MISO long before the first data-phase rise.
      if (w_cmd_done) begin
        r_addr <= w_word[ADDR_W+2:3];
        r_tx   <= r_mem[w_word[ADDR_W+2:3]];
      end else if (w_rd_shift) begin
        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end

      if (w_wr_done) begin
        r_mem[r_addr] <= w_word;
        led           <= w_word;
      end
    end
  end

endmodule

// File: tb/tb_slave_top.sv
// Directed bench for slave_top: table of SPI frames with hand-computed results,
// plus a hand-written reset-during-read sequence.
module tb_slave_top;

  logic        clk = 1'b0;
  logic        rst_btn;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic [15:0] led;

  int total = 0;
  int bad   = 0;

  slave_top #(
    .SYNC_STAGES(2),
    .ADDR_W     (8),
    .DATA_W     (16)
  ) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .spi_sclk_in (sclk),
    .spi_mosi_in (mosi),
    .spi_cs_n_in (cs_n),
    .spi_miso_out(miso),
    .led         (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic [7:0]  addr;
    logic [15:0] data;
    int          nbits;
    logic [15:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_word(input logic is_rd, input logic [7:0] addr,
                                             input logic [15:0] data);
    return {5'b00000, addr, 1'b0, is_rd, 1'b0, data};
  endfunction

  // SCLK low 2 clk, high 2 clk (25 MHz); master samples MISO just before each rise.
  task automatic spi_bits(input logic [31:0] word, input int nbits, output logic [15:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[31-i];
      tick(2);
      if (i >= 16) rd = {rd[14:0], miso};
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [15:0] rd);
    cs_n = 1'b0;
    tick(4);
    spi_bits(word, nbits, rd);
    tick(2);
    cs_n = 1'b1;
    tick(5);
  endtask

  initial begin
    logic [15:0] rd;

    vecs[0]  = '{1'b0, 8'h05, 16'hAAAA, 32, 16'h0000, 16'hAAAA};
    vecs[1]  = '{1'b1, 8'h05, 16'h0000, 32, 16'hAAAA, 16'hAAAA};
    vecs[2]  = '{1'b0, 8'h42, 16'h1234, 32, 16'h0000, 16'h1234};
    vecs[3]  = '{1'b1, 8'h42, 16'h0000, 32, 16'h1234, 16'h1234};
    vecs[4]  = '{1'b1, 8'h05, 16'h0000, 32, 16'hAAAA, 16'h1234};
    vecs[5]  = '{1'b0, 8'h10, 16'hBEEF, 20, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b1, 8'h10, 16'h0000, 32, 16'h0000, 16'h1234};
    vecs[7]  = '{1'b1, 8'hFF, 16'h0000, 32, 16'h0000, 16'h1234};
    vecs[8]  = '{1'b0, 8'hFF, 16'h8001, 32, 16'h0000, 16'h8001};
    vecs[9]  = '{1'b1, 8'hFF, 16'h0000, 32, 16'h8001, 16'h8001};
    vecs[10] = '{1'b0, 8'h00, 16'h7FFE, 32, 16'h0000, 16'h7FFE};
    vecs[11] = '{1'b1, 8'h00, 16'h0000, 32, 16'h7FFE, 16'h7FFE};
    vecs[12] = '{1'b1, 8'hFF, 16'h0000, 32, 16'h8001, 16'h7FFE};

    rst_btn = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cs_n    = 1'b1;
    tick(5);
    rst_btn = 1'b0;
    tick(3);
    check("reset_led", led, 16'h0000);
    check("reset_miso", {15'd0, miso}, 16'h0000);

    for (int v = 0; v < 13; v++) begin
      spi_frame(frame_word(vecs[v].is_rd, vecs[v].addr, vecs[v].data), vecs[v].nbits, rd);
      check($sformatf("vec%0d_miso_data", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
      check($sformatf("vec%0d_miso_idle", v), {15'd0, miso}, 16'h0000);
    end

    // Reset in the middle of a read of 0xFF (holds 0x8001, MSB already on MISO).
    cs_n = 1'b0;
    tick(4);
    spi_bits(frame_word(1'b1, 8'hFF, 16'h0000), 16, rd);
    tick(3);
    check("midread_msb", {15'd0, miso}, 16'h0001);
    rst_btn = 1'b1;
    tick(1);
    check("midread_rst_miso", {15'd0, miso}, 16'h0000);
    check("midread_rst_led", led, 16'h0000);
    rst_btn = 1'b0;
    tick(4);
    sclk = 1'b1;
    tick(2);
    sclk = 1'b0;
    tick(2);
    check("postrst_no_frame", {15'd0, miso}, 16'h0000);
    cs_n = 1'b1;
    tick(5);

    spi_frame(frame_word(1'b0, 8'h33, 16'h5A5A), 32, rd);
    check("postrst_wr_led", led, 16'h5A5A);
    spi_frame(frame_word(1'b1, 8'h33, 16'h0000), 32, rd);
    check("postrst_rd33", rd, 16'h5A5A);
    spi_frame(frame_word(1'b1, 8'hFF, 16'h0000), 32, rd);
    check("postrst_rdFF_cleared", rd, 16'h0000);
    check("postrst_led", led, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
